// File: rtl/ecc_sed_checker.sv
// Single-error-detect parity checker feeding a 2-entry FIFO toward the decoder side.
// Optional error counter is enabled with ECC_SED_CHECKER_ERR_COUNT_EN (default build: err_count tied to 0).
module ecc_sed_checker (
   input  logic        clk,
   input  logic        rst,
   input  logic        enc_valid,
   input  logic [12:0] enc_codeword,
   input  logic        dec_ready,
   input  logic        err_clr,
   output logic        dec_valid,
   output logic [11:0] dec_data,
   output logic        dec_err,
   output logic [1:0]  fifo_level,
   output logic        overflow,
   output logic [7:0]  err_count
);

   logic [12:0] mem [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  level;
   logic        in_err;
   logic        pop;
   logic        push;
   logic        drop;
   logic [12:0] head;

   assign in_err    = ^enc_codeword;
   assign dec_valid = (level != 2'd0);
   assign pop       = dec_valid & dec_ready;
   // A full FIFO still accepts when the head leaves in the same cycle.
   assign push      = enc_valid & ((level != 2'd2) | pop);
   assign drop      = enc_valid & (level == 2'd2) & ~pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         level  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {in_err, enc_codeword[11:0]};
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   level <= level + 2'd1;
            2'b01:   level <= level - 2'd1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         overflow <= 1'b0;
      else if (drop)    overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
   end

`ifdef ECC_SED_CHECKER_ERR_COUNT_EN
   logic [7:0] err_cnt_q;
   logic       err_event;

   assign err_event = push & in_err;

   // A clear coinciding with a new error restarts the count at 1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                err_cnt_q <= 8'd0;
      else if (err_clr)                        err_cnt_q <= err_event ? 8'd1 : 8'd0;
      else if (err_event && err_cnt_q != 8'hff) err_cnt_q <= err_cnt_q + 8'd1;
   end

   assign err_count = err_cnt_q;
`else
   assign err_count = 8'd0;
`endif

   assign head       = mem[rd_ptr];
   assign dec_data   = dec_valid ? head[11:0] : 12'd0;
   assign dec_err    = dec_valid & head[12];
   assign fifo_level = level;

endmodule

// File: tb/tb_ecc_sed_checker.sv
// Randomized bench for ecc_sed_checker against a queue-based reference model.
module tb_ecc_sed_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enc_valid = 1'b0;
   logic [12:0] enc_codeword = '0;
   logic        dec_ready = 1'b0;
   logic        err_clr = 1'b0;
   logic        dec_valid;
   logic [11:0] dec_data;
   logic        dec_err;
   logic [1:0]  fifo_level;
   logic        overflow;
   logic [7:0]  err_count;

   int n_checks = 0;
   int n_pass   = 0;

   logic [12:0] q [$];
   logic        m_ovf = 1'b0;
   int          m_cnt = 0;

   ecc_sed_checker dut (
      .clk          (clk),
      .rst          (rst),
      .enc_valid    (enc_valid),
      .enc_codeword (enc_codeword),
      .dec_ready    (dec_ready),
      .err_clr      (err_clr),
      .dec_valid    (dec_valid),
      .dec_data     (dec_data),
      .dec_err      (dec_err),
      .fifo_level   (fifo_level),
      .overflow     (overflow),
      .err_count    (err_count)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic check_outputs();
      logic [12:0] h;
      h = (q.size() > 0) ? q[0] : 13'd0;
      chk("dec_valid", 32'(dec_valid), 32'(q.size() > 0));
      chk("dec_data", 32'(dec_data), 32'(h[11:0]));
      chk("dec_err", 32'(dec_err), 32'(h[12]));
      chk("fifo_level", 32'(fifo_level), 32'(q.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("err_count", 32'(err_count), 32'(m_cnt));
   endtask

   task automatic cycle(input logic v, input logic [12:0] cw, input logic rdy, input logic clr);
      logic pop, accept, ev;
      @(negedge clk);
      enc_valid = v; enc_codeword = cw; dec_ready = rdy; err_clr = clr;
      @(posedge clk);
      pop    = (q.size() > 0) && rdy;
      accept = v && ((q.size() < 2) || pop);
      if (pop) void'(q.pop_front());
      if (accept) q.push_back({^cw, cw[11:0]});
      if (v && !accept) m_ovf = 1'b1;
      else if (clr)     m_ovf = 1'b0;
`ifdef ECC_SED_CHECKER_ERR_COUNT_EN
      ev = accept && (^cw);
      if (clr)                   m_cnt = ev ? 1 : 0;
      else if (ev && m_cnt < 255) m_cnt++;
`else
      ev = 1'b0;
`endif
      #1 check_outputs();
   endtask

   task automatic apply_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst_dec_valid", 32'(dec_valid), 32'd0);
      chk("rst_dec_data", 32'(dec_data), 32'd0);
      chk("rst_dec_err", 32'(dec_err), 32'd0);
      chk("rst_fifo_level", 32'(fifo_level), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      q.delete(); m_ovf = 1'b0; m_cnt = 0;
      enc_valid = 1'b0; dec_ready = 1'b0; err_clr = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #1;
      chk("por_dec_valid", 32'(dec_valid), 32'd0);
      chk("por_fifo_level", 32'(fifo_level), 32'd0);
      #20 rst = 1'b1;

      // Clean and corrupted single words
      cycle(1'b1, 13'h1001, 1'b1, 1'b0);
      chk("clean_data", 32'(dec_data), 32'h001);
      chk("clean_err", 32'(dec_err), 32'd0);
      cycle(1'b1, 13'h0001, 1'b1, 1'b0);
      chk("bad_data", 32'(dec_data), 32'h001);
      chk("bad_err", 32'(dec_err), 32'd1);
`ifdef ECC_SED_CHECKER_ERR_COUNT_EN
      chk("bad_count", 32'(err_count), 32'd1);
`else
      chk("bad_count", 32'(err_count), 32'd0);
`endif
      cycle(1'b0, 13'h0, 1'b1, 1'b0);

      // Overflow: A, B, C with no consumer
      cycle(1'b1, 13'h0000, 1'b0, 1'b0);
      cycle(1'b1, 13'h1003, 1'b0, 1'b0);
      cycle(1'b1, 13'h0555, 1'b0, 1'b0);
      chk("ovf_level", 32'(fifo_level), 32'd2);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_head_a", 32'(dec_data), 32'h000);
      cycle(1'b0, 13'h0, 1'b1, 1'b0);
      chk("ovf_head_b", 32'(dec_data), 32'h003);
      cycle(1'b0, 13'h0, 1'b1, 1'b0);
      chk("ovf_empty", 32'(dec_valid), 32'd0);
      cycle(1'b0, 13'h0, 1'b1, 1'b1);
      chk("ovf_cleared", 32'(overflow), 32'd0);

      // Full FIFO with simultaneous push/pop
      cycle(1'b1, 13'h0011, 1'b0, 1'b0);
      cycle(1'b1, 13'h0022, 1'b0, 1'b0);
      cycle(1'b1, 13'h0033, 1'b1, 1'b0);
      chk("pp_level", 32'(fifo_level), 32'd2);
      chk("pp_ovf", 32'(overflow), 32'd0);
      chk("pp_head", 32'(dec_data), 32'h022);
      cycle(1'b0, 13'h0, 1'b1, 1'b0);
      chk("pp_next", 32'(dec_data), 32'h033);
      cycle(1'b0, 13'h0, 1'b1, 1'b0);

      // Counter saturation and clear
      for (int i = 0; i < 300; i++) cycle(1'b1, 13'h0001, 1'b1, 1'b0);
`ifdef ECC_SED_CHECKER_ERR_COUNT_EN
      chk("sat_count", 32'(err_count), 32'd255);
`else
      chk("sat_count", 32'(err_count), 32'd0);
`endif
      cycle(1'b0, 13'h0, 1'b1, 1'b1);
      chk("clr_count", 32'(err_count), 32'd0);
      cycle(1'b1, 13'h0001, 1'b1, 1'b1);

      // Async reset while full and overflowed, then normal capture
      cycle(1'b1, 13'h1001, 1'b0, 1'b0);
      cycle(1'b1, 13'h0002, 1'b0, 1'b0);
      cycle(1'b1, 13'h0004, 1'b0, 1'b0);
      apply_reset();
      cycle(1'b1, 13'h1ABC, 1'b0, 1'b0);
      chk("post_rst_data", 32'(dec_data), 32'hABC);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         cycle(1'($urandom_range(0, 99) < 60), 13'($urandom),
               1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 5));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
